// File: rtl/median_pkg.sv
// Shared constants, FSM state type and window index helper for the
// 5x5 median window controller.
package median_pkg;

  localparam int WIN_SIZE       = 5;
  localparam int ELEMENT_NUM    = 25;
  localparam int CENTER_IDX     = 12;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  function automatic int win_idx(input int r, input int c);
    return r * WIN_SIZE + c;
  endfunction

endpackage

// File: rtl/median_line_buffer.sv
// One-row delay line: circular RAM of DEPTH entries with a wrapping address.
// Ports: clk, rst_n, en (advance), din (new pixel), dout (pixel DEPTH enables ago).
module median_line_buffer
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         addr;

  // Read returns the old entry before this enable overwrites it.
  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (en) begin
      addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/median_window_ctrl.sv
// Frame sequencer for the 5x5 median datapath: buffers rows, builds windows,
// re-times med_in into out_valid/out_data/out_last and pulses frame_done.
// Ports: start/busy, in_valid/in_data/in_ready, win_pixels/win_valid,
// med_in, out_valid/out_data/out_last, frame_done.
// Optional MEDIAN_BYPASS_EN adds input bypass (output window center).
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ELEMENT_NUM    = 25,
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int MEDIAN_LATENCY = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic [ELEMENT_NUM*DATA_WIDTH-1:0] win_pixels,
  output logic                              win_valid,
  input  logic [DATA_WIDTH-1:0]             med_in,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              frame_done
`ifdef MEDIAN_BYPASS_EN
  ,
  input  logic                              bypass
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int DW = $clog2(MEDIAN_LATENCY + 1) + 1;
  localparam int L  = MEDIAN_LATENCY;

  state_t state, nstate;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] dcnt;

  logic xfer;
  logic col_end;
  logic row_end;
  logic win_ok;
  logic win_last;

  logic [DATA_WIDTH-1:0] r1, r2, r3, r4;
  logic [DATA_WIDTH-1:0] rowtap [WIN_SIZE];
  logic [DATA_WIDTH-1:0] win [WIN_SIZE][WIN_SIZE];

  logic [L-1:0] vpipe;
  logic [L-1:0] lpipe;

  assign xfer    = in_valid & in_ready;
  assign col_end = (col == CW'(IMG_WIDTH - 1));
  assign row_end = (row == RW'(IMG_HEIGHT - 1));
  assign win_ok  = (row >= RW'(4)) && (col >= CW'(4));

  assign busy       = (state != IDLE);
  assign in_ready   = (state == LOAD);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = LOAD;
      LOAD:    if (xfer && col_end && row_end) nstate = DRAIN;
      DRAIN:   if (dcnt == DW'(L)) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // DRAIN covers the window register stage plus the latency pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              dcnt <= '0;
    else if (state == DRAIN) dcnt <= dcnt + 1'b1;
    else                     dcnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en(xfer), .din(in_data), .dout(r1)
  );
  median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(xfer), .din(r1), .dout(r2)
  );
  median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .en(xfer), .din(r2), .dout(r3)
  );
  median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb3 (
    .clk(clk), .rst_n(rst_n), .en(xfer), .din(r3), .dout(r4)
  );

  // Window row 0 is the oldest image row.
  always_comb begin
    rowtap[0] = r4;
    rowtap[1] = r3;
    rowtap[2] = r2;
    rowtap[3] = r1;
    rowtap[4] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_SIZE; r++)
        for (int c = 0; c < WIN_SIZE; c++)
          win[r][c] <= '0;
    end else if (xfer) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE - 1; c++)
          win[r][c] <= win[r][c+1];
        win[r][WIN_SIZE-1] <= rowtap[r];
      end
    end
  end

  always_comb begin
    win_pixels = '0;
    for (int r = 0; r < WIN_SIZE; r++)
      for (int c = 0; c < WIN_SIZE; c++)
        win_pixels[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= xfer & win_ok;
      win_last  <= xfer & col_end & row_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe[0] <= win_valid;
      lpipe[0] <= win_last;
      for (int i = 1; i < L; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

  assign out_valid = vpipe[L-1];
  assign out_last  = lpipe[L-1];

`ifdef MEDIAN_BYPASS_EN
  logic                  win_byp;
  logic [L-1:0]          bpipe;
  logic [DATA_WIDTH-1:0] cpipe [L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_byp <= 1'b0;
    else        win_byp <= xfer & win_ok & bypass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpipe <= '0;
      for (int i = 0; i < L; i++) cpipe[i] <= '0;
    end else begin
      bpipe[0] <= win_byp;
      cpipe[0] <= win[CENTER_IDX / WIN_SIZE][CENTER_IDX % WIN_SIZE];
      for (int i = 1; i < L; i++) begin
        bpipe[i] <= bpipe[i-1];
        cpipe[i] <= cpipe[i-1];
      end
    end
  end

  assign out_data = bpipe[L-1] ? cpipe[L-1] : med_in;
`else
  assign out_data = med_in;
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Scoreboard bench for median_window_ctrl on an 8x6 image, latency 3.
// A behavioural median stage drives med_in from the DUT window bus.
`timescale 1ns/1ps
module tb_median_window_ctrl;

  localparam int DW   = 8;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int L    = 3;
  localparam int NOUT = (W - 4) * (H - 4);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          bypass = 1'b0;
  logic          busy, in_ready, win_valid;
  logic          out_valid, out_last, frame_done;
  logic [25*DW-1:0] win_pixels;
  logic [DW-1:0] med_in, out_data;

  always #5 clk = ~clk;

  median_window_ctrl #(
    .DATA_WIDTH(DW), .ELEMENT_NUM(25), .IMG_WIDTH(W),
    .IMG_HEIGHT(H), .MEDIAN_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .win_pixels(win_pixels), .win_valid(win_valid), .med_in(med_in),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .frame_done(frame_done)
`ifdef MEDIAN_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int median25(input logic [25*DW-1:0] w);
    int v [25];
    int t;
    for (int i = 0; i < 25; i++) v[i] = int'(w[i*DW +: DW]);
    for (int i = 0; i < 24; i++)
      for (int j = 0; j < 24 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[12];
  endfunction

  // Behavioural calculate_median: L register stages.
  logic [DW-1:0] mq [L];
  always @(posedge clk) begin
    mq[0] <= DW'(median25(win_pixels));
    for (int i = 1; i < L; i++) mq[i] <= mq[i-1];
  end
  assign med_in = mq[L-1];

  typedef struct {
    int d;
    int last;
  } exp_t;

  exp_t exp_q [$];
  int   wv_q [$];
  int   img [W*H];
  int   cyc = 0;
  int   n_out = 0;
  int   n_fd = 0;
  int   fd0 = 0;
  int   lo_cyc = 0;
  int   fd_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (win_valid) wv_q.push_back(cyc);
    if (out_valid) begin
      n_out++;
      lo_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("stray_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(out_data), e.d);
        chk("out_last", int'(out_last), e.last);
      end
      if (wv_q.size() > 0) chk("latency", cyc - wv_q.pop_front(), L);
      else                 chk("latency_nowin", 1, 0);
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on_start", int'(busy), 1);
    chk("ready_on_start", int'(in_ready), 1);
  endtask

  // kind: 0 constant 100, 1 ramp, 2 impulse at (3,3).
  task automatic send_frame(input int kind, input bit gaps,
                            input int npix, input int start_at);
    int idx, guard, r, c;
    bit v, xf, sent;
    exp_t e;
    logic [25*DW-1:0] wb;
    for (int i = 0; i < W*H; i++) begin
      case (kind)
        0:       img[i] = 100;
        1:       img[i] = (i / W) * 8 + (i % W);
        default: img[i] = (i == 3*W + 3) ? 255 : 0;
      endcase
    end
    n_out = 0;
    fd0   = n_fd;
    do_start();
    idx = 0; guard = 0; sent = 1'b0;
    while (idx < npix && guard < 4*W*H + 50) begin
      v = gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
      in_valid = v;
      in_data  = DW'(img[idx]);
      start    = (idx == start_at) && !sent;
      if (start) sent = 1'b1;
      xf = v && in_ready;
      @(posedge clk);
      if (xf) begin
        r = idx / W;
        c = idx % W;
        if (r >= 4 && c >= 4) begin
          for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
              wb[(rr*5+cc)*DW +: DW] = DW'(img[(r-4+rr)*W + c-4+cc]);
          e.d    = bypass ? img[(r-2)*W + c-2] : median25(wb);
          e.last = (r == H-1 && c == W-1) ? 1 : 0;
          exp_q.push_back(e);
        end
        idx++;
      end
      #1;
      start = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < npix) chk("send_timeout", idx, npix);
  endtask

  task automatic wait_frame();
    int g = 0;
    while (n_fd == fd0 && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    chk("frame_done_seen", n_fd - fd0, 1);
    chk("out_count", n_out, NOUT);
    chk("fd_after_last", (fd_cyc - lo_cyc >= 1) ? 1 : 0, 1);
    @(negedge clk); #1;
    chk("busy_low", int'(busy), 0);
    chk("fd_pulse", int'(frame_done), 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_win_zero", (win_pixels == '0) ? 1 : 0, 1);
    rst_n = 1'b1;

    send_frame(0, 1'b0, W*H, -1);
    wait_frame();

    send_frame(1, 1'b0, W*H, -1);
    wait_frame();

`ifdef MEDIAN_BYPASS_EN
    bypass = 1'b1;
    send_frame(2, 1'b0, W*H, -1);
    wait_frame();
    bypass = 1'b0;
`endif
    send_frame(2, 1'b0, W*H, -1);
    wait_frame();

    send_frame(1, 1'b1, W*H, -1);
    wait_frame();

    send_frame(1, 1'b0, W*H, 20);
    wait_frame();

    send_frame(1, 1'b0, 20, -1);
    rst_n = 1'b0;
    exp_q.delete();
    wv_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("midrst_no_out", n_out, 0);
    chk("midrst_no_fd", n_fd - fd0, 0);
    chk("midrst_idle", int'(busy), 0);

    send_frame(1, 1'b0, W*H, -1);
    wait_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
